// File: rtl/hazard_scoreboard.sv
// Per-register RAW/ECALL hazard scoreboard that sits beside the ID stage.
// Each architectural register has a countdown of the cycles left before its
// in-flight result can be forwarded. ECALL reads its argument register straight
// from the register file, so that one register also has a write-back countdown.

// One countdown per register. A load from the decoder takes priority over the
// decrement. The count stops at zero and freezes while the pipeline is held.
module hazard_cnt #(
    parameter int LAT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hold,
    input  logic             load,
    input  logic [LAT_W-1:0] lat,
    output logic [LAT_W-1:0] cnt
);

    // Load the new latency on issue; otherwise count down toward zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (!hold) begin
            if (load) begin
                cnt <= lat;
            end else if (cnt != '0) begin
                cnt <= cnt - LAT_W'(1);
            end
        end
    end

endmodule

module hazard_scoreboard #(
    parameter int NUM_REGS  = 32,
    parameter int ADDR_W    = 5,
    parameter int LAT_W     = 3,
    parameter int ECALL_REG = 17,
    parameter int CNT_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] id_rs1,
    input  logic [ADDR_W-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic              id_is_ecall,
    input  logic              id_reg_write,
    input  logic [ADDR_W-1:0] id_rd,
    input  logic [LAT_W-1:0]  id_fwd_lat,
    input  logic [LAT_W-1:0]  id_wb_lat,
    input  logic              flush,
    input  logic              hold,
    output logic              is_stall,
    output logic [1:0]        stall_cause,
    output logic [CNT_W-1:0]  stall_cycles
);

    // Entry 0 is x0 and always reads as zero.
    logic [NUM_REGS-1:0][LAT_W-1:0] fwd_cnt;
    logic [LAT_W-1:0]               ecall_wb_cnt;
    logic [LAT_W-1:0]               rs1_cnt;
    logic [LAT_W-1:0]               rs2_cnt;
    logic                           data_haz;
    logic                           ecall_haz;
    logic                           issue;
    logic                           ecall_load;

    assign fwd_cnt[0] = '0;

    // One forwarding countdown per tracked register, x1..NUM_REGS-1.
    // Decoding id_rd against the register index also drops writes to x0 and
    // to any out-of-range rd, because those match no instance.
    for (genvar g = 1; g < NUM_REGS; g++) begin : g_reg
        logic sel;
        assign sel = issue & id_reg_write & (id_rd == ADDR_W'(g));
        hazard_cnt #(.LAT_W(LAT_W)) u_fwd (
            .clk   (clk),
            .reset (reset),
            .hold  (hold),
            .load  (sel),
            .lat   (id_fwd_lat),
            .cnt   (fwd_cnt[g])
        );
    end

    // The write-back countdown matters only to consumers that skip the
    // forwarding network. ECALL is the only such consumer, so only its
    // argument register keeps a write-back count.
    assign ecall_load = issue & id_reg_write & (id_rd == ADDR_W'(ECALL_REG));

    hazard_cnt #(.LAT_W(LAT_W)) u_ecall_wb (
        .clk   (clk),
        .reset (reset),
        .hold  (hold),
        .load  (ecall_load),
        .lat   (id_wb_lat),
        .cnt   (ecall_wb_cnt)
    );

    // Look up the source counts. A source index with no matching register
    // (x0, or an index >= NUM_REGS) reads as zero.
    always_comb begin
        rs1_cnt = '0;
        rs2_cnt = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (id_rs1 == ADDR_W'(r)) rs1_cnt = fwd_cnt[r];
            if (id_rs2 == ADDR_W'(r)) rs2_cnt = fwd_cnt[r];
        end
    end

    // The hazard terms use the counts from before this edge. A self-dependent
    // instruction therefore checks the older producer first and then loads
    // its own count.
    assign data_haz  = id_valid & ((id_use_rs1 & (rs1_cnt != '0)) |
                                   (id_use_rs2 & (rs2_cnt != '0)));
    assign ecall_haz = id_valid & id_is_ecall & (ecall_wb_cnt != '0);

    // A flushed instruction never stalls and never issues. Older producers
    // keep counting down, because they are still in flight.
    assign is_stall    = (data_haz | ecall_haz) & ~flush;
    assign stall_cause = {ecall_haz & ~flush, data_haz & ~flush};
    assign issue       = id_valid & ~is_stall & ~flush & ~hold;

    // Count the stalled cycles, excluding held cycles. The counter saturates
    // instead of wrapping, and only reset clears it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles <= '0;
        end else if (is_stall && !hold && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard. It runs a default build plus a CNT_W=4
// build on the same stimulus, so the second build shows stall-counter
// saturation.
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_use_rs1;
    logic       id_use_rs2;
    logic       id_is_ecall;
    logic       id_reg_write;
    logic [4:0] id_rd;
    logic [2:0] id_fwd_lat;
    logic [2:0] id_wb_lat;
    logic       flush;
    logic       hold;

    logic        is_stall;
    logic [1:0]  stall_cause;
    logic [31:0] stall_cycles;
    logic        is_stall4;
    logic [1:0]  stall_cause4;
    logic [3:0]  stall_cycles4;

    int n_chk = 0;
    int n_err = 0;
    int exp_sc = 0;

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_is_ecall(id_is_ecall), .id_reg_write(id_reg_write),
        .id_rd(id_rd), .id_fwd_lat(id_fwd_lat), .id_wb_lat(id_wb_lat),
        .flush(flush), .hold(hold),
        .is_stall(is_stall), .stall_cause(stall_cause),
        .stall_cycles(stall_cycles)
    );

    hazard_scoreboard #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_is_ecall(id_is_ecall), .id_reg_write(id_reg_write),
        .id_rd(id_rd), .id_fwd_lat(id_fwd_lat), .id_wb_lat(id_wb_lat),
        .flush(flush), .hold(hold),
        .is_stall(is_stall4), .stall_cause(stall_cause4),
        .stall_cycles(stall_cycles4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Present one ID-stage instruction at the falling edge, then settle.
    task automatic op(input logic v, input logic [4:0] rs1, input logic u1,
                      input logic [4:0] rs2, input logic u2, input logic ec,
                      input logic rw, input logic [4:0] rd,
                      input logic [2:0] fl, input logic [2:0] wl,
                      input logic fls, input logic hd);
        @(negedge clk);
        id_valid = v; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
        id_is_ecall = ec; id_reg_write = rw; id_rd = rd;
        id_fwd_lat = fl; id_wb_lat = wl; flush = fls; hold = hd;
        #1;
    endtask

    task automatic chk_sc(input string tag);
        chk({tag, "_sc"}, stall_cycles, exp_sc);
        chk({tag, "_sc4"}, {28'd0, stall_cycles4}, (exp_sc > 15) ? 15 : exp_sc);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        id_is_ecall = 0; id_reg_write = 0; id_rd = 0;
        id_fwd_lat = 0; id_wb_lat = 0; flush = 0; hold = 0;
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Reset state: a valid reader of x5 sees no hazard.
        op(1, 5, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_stall", is_stall, 0);
        chk("rst_cause", stall_cause, 0);
        chk_sc("rst");

        // T1: lw x5 (fwd1, wb3) followed by add x6,x5,x1 -> one bubble.
        op(1, 1, 0, 0, 0, 0, 1, 5, 1, 3, 0, 0);
        chk("t1_lw", is_stall, 0);
        op(1, 5, 1, 1, 1, 0, 1, 6, 0, 1, 0, 0);
        chk("t1_dep_stall", is_stall, 1);
        chk("t1_dep_cause", stall_cause, 1);
        exp_sc++;
        op(1, 5, 1, 1, 1, 0, 1, 6, 0, 1, 0, 0);
        chk("t1_dep_go", is_stall, 0);
        chk_sc("t1");

        // T2: ALU producer forwards at once; non-reading consumer ignores a load.
        op(1, 0, 0, 0, 0, 0, 1, 5, 0, 1, 0, 0);
        op(1, 5, 1, 5, 1, 0, 1, 7, 0, 1, 0, 0);
        chk("t2_alu_dep", is_stall, 0);
        op(1, 0, 0, 0, 0, 0, 1, 5, 1, 3, 0, 0);
        op(1, 5, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("t2_nouse", is_stall, 0);

        // T3: addi x17 (wb2) then ecall -> two ecall stalls.
        op(1, 0, 0, 0, 0, 0, 1, 17, 0, 2, 0, 0);
        op(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        chk("t3_ec1", is_stall, 1);
        chk("t3_ec1_cause", stall_cause, 2);
        op(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        chk("t3_ec2", is_stall, 1);
        op(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        chk("t3_ec3", is_stall, 0);
        exp_sc += 2;
        // Independent instruction in between -> one stall.
        op(1, 0, 0, 0, 0, 0, 1, 17, 0, 2, 0, 0);
        op(1, 0, 0, 0, 0, 0, 1, 10, 0, 1, 0, 0);
        chk("t3_indep", is_stall, 0);
        op(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        chk("t3_gap_ec1", stall_cause, 2);
        op(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        chk("t3_gap_ec2", is_stall, 0);
        exp_sc += 1;
        // Load x17 (fwd1, wb2) then an ecall that also reads x17 -> cause 3, then 2.
        op(1, 0, 0, 0, 0, 0, 1, 17, 1, 2, 0, 0);
        op(1, 17, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        chk("t3_both", stall_cause, 3);
        op(1, 17, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        chk("t3_both2_stall", is_stall, 1);
        chk("t3_both2_cause", stall_cause, 2);
        op(1, 17, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        chk("t3_both3", is_stall, 0);
        exp_sc += 2;
        chk_sc("t3");

        // T4: mul x9 (fwd4) with a three-cycle hold inside the stall window.
        op(1, 0, 0, 0, 0, 0, 1, 9, 4, 5, 0, 0);
        op(1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("t4_s1", is_stall, 1);
        exp_sc++;
        for (int i = 0; i < 3; i++) begin
            op(1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
            chk("t4_hold_stall", is_stall, 1);
            chk_sc("t4_hold");
        end
        for (int i = 0; i < 3; i++) begin
            op(1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            chk("t4_post_stall", is_stall, 1);
            exp_sc++;
        end
        op(1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("t4_done", is_stall, 0);
        chk_sc("t4");

        // T5: flush cancels the stall and the issue; the older count keeps decrementing.
        op(1, 0, 0, 0, 0, 0, 1, 5, 1, 3, 0, 0);
        op(1, 5, 1, 0, 0, 0, 1, 8, 3, 3, 1, 0);
        chk("t5_flush_stall", is_stall, 0);
        chk("t5_flush_cause", stall_cause, 0);
        op(1, 8, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("t5_after_flush", is_stall, 0);
        op(1, 0, 0, 0, 0, 0, 1, 0, 3, 3, 0, 0);
        op(1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("t5_x0", is_stall, 0);

        // Self-dependency: lw x5,0(x5) behind lw x5 -> one stall, then one more.
        op(1, 0, 0, 0, 0, 0, 1, 5, 1, 2, 0, 0);
        op(1, 5, 1, 0, 0, 0, 1, 5, 1, 2, 0, 0);
        chk("self_s1", is_stall, 1);
        op(1, 5, 1, 0, 0, 0, 1, 5, 1, 2, 0, 0);
        chk("self_issue", is_stall, 0);
        op(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("self_s2", is_stall, 1);
        op(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("self_done", is_stall, 0);
        exp_sc += 2;
        chk_sc("self");

        // T6: a max-latency mul pushes the CNT_W=4 counter past 15.
        op(1, 0, 0, 0, 0, 0, 1, 9, 7, 7, 0, 0);
        for (int i = 0; i < 7; i++) begin
            op(1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            chk("t6_mul_stall", is_stall, 1);
            exp_sc++;
        end
        op(1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("t6_mul_done", is_stall, 0);
        chk_sc("t6_sat");

        // Reset pulsed in the middle of a mul countdown.
        op(1, 0, 0, 0, 0, 0, 1, 9, 7, 7, 0, 0);
        op(1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("t6_pre_rst", is_stall, 1);
        reset = 1'b0;
        #1;
        chk("t6_rst_stall", is_stall, 0);
        exp_sc = 0;
        chk_sc("t6_rst");
        @(negedge clk);
        reset = 1'b1;
        op(1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("t6_post_rst", is_stall, 0);
        op(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        chk("t6_post_rst_ec", is_stall, 0);
        chk_sc("t6_end");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
